// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO holding {inst, pc} with valid/ready handshakes and flush.
// Optional same-cycle empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int INST_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_W-1:0]          in_inst,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_W-1:0]          out_inst,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic stored_valid, not_full, open, bypass, push, pop;

  // Reset and flush both close the handshakes in the cycle they are asserted.
  assign open         = !flush && !reset;
  assign stored_valid = (count_reg != '0);
  assign not_full     = (count_reg != FULL_COUNT);
  assign in_ready     = not_full && open;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass   = !stored_valid && in_valid && out_ready && open;
  assign out_inst = bypass ? in_inst : inst_mem[rd_ptr_reg];
  assign out_pc   = bypass ? in_pc   : pc_mem[rd_ptr_reg];
`else
  assign bypass   = 1'b0;
  assign out_inst = inst_mem[rd_ptr_reg];
  assign out_pc   = pc_mem[rd_ptr_reg];
`endif

  assign out_valid = (stored_valid && open) || bypass;
  assign push      = in_valid && in_ready && !bypass;
  assign pop       = stored_valid && open && out_ready;
  assign count     = count_reg;

  // Slot contents are never cleared; only pointers and count are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_reg] <= in_inst;
      pc_mem[wr_ptr_reg]   <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Table-driven bench for fetch_queue (DEPTH=8); expectations follow FETCH_QUEUE_BYPASS_EN if defined.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_inst, out_pc;
  logic [3:0]  count;

  int tests  = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(8), .INST_W(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        rs;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic void add(input logic iv, input logic [31:0] pc, input logic ordy,
                              input logic fl, input logic rs, input logic e_ir,
                              input logic e_ov, input logic [31:0] e_pc, input logic [3:0] e_cnt);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ordy = ordy; v.fl = fl; v.rs = rs;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic check1(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rs; flush = v.fl; in_valid = v.iv; in_pc = v.pc; in_inst = inst_of(v.pc);
    out_ready = v.ordy;
    #1;
    check1("in_ready", idx, {31'b0, in_ready}, {31'b0, v.e_ir});
    check1("out_valid", idx, {31'b0, out_valid}, {31'b0, v.e_ov});
    if (!v.rs) check1("count", idx, {28'b0, count}, {28'b0, v.e_cnt});
    if (v.e_ov) begin
      check1("out_pc", idx, out_pc, v.e_pc);
      check1("out_inst", idx, out_inst, inst_of(v.e_pc));
    end
    $display("[TB] vec %0d rs=%0b fl=%0b iv=%0b pc=%h ordy=%0b | ir=%0b ov=%0b opc=%h cnt=%0d",
             idx, v.rs, v.fl, v.iv, v.pc, v.ordy, in_ready, out_valid, out_pc, count);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;

    // Basic ordering: push 3 with out_ready low, then pop 3.
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 32'h100, 0, 0, 0, 1, 0, 0, 0);
    add(1, 32'h104, 0, 0, 0, 1, 1, 32'h100, 1);
    add(1, 32'h108, 0, 0, 0, 1, 1, 32'h100, 2);
    add(0, 0, 0, 0, 0, 1, 1, 32'h100, 3);
    add(0, 0, 1, 0, 0, 1, 1, 32'h100, 3);
    add(0, 0, 1, 0, 0, 1, 1, 32'h104, 2);
    add(0, 0, 1, 0, 0, 1, 1, 32'h108, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Fill to DEPTH, reject a 9th push, one pop reopens in_ready.
    for (int i = 0; i < 8; i++)
      add(1, 32'h300 + 32'(4 * i), 0, 0, 0, 1, i != 0, 32'h300, 4'(i));
    add(1, 32'h3FC, 0, 0, 0, 0, 1, 32'h300, 8);
    add(0, 0, 1, 0, 0, 0, 1, 32'h300, 8);
    add(0, 0, 0, 0, 0, 1, 1, 32'h304, 7);
    for (int i = 1; i < 8; i++)
      add(0, 0, 1, 0, 0, 1, 1, 32'h300 + 32'(4 * i), 4'(8 - i));
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Wrap-around: one primed entry, then 20 cycles of simultaneous push and pop.
    add(1, 32'h400, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      add(1, 32'h404 + 32'(4 * i), 1, 0, 0, 1, 1, 32'h400 + 32'(4 * i), 1);
    add(0, 0, 1, 0, 0, 1, 1, 32'h450, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Flush with count=5 and a push presented in the flush cycle.
    for (int i = 0; i < 5; i++)
      add(1, 32'h500 + 32'(4 * i), 0, 0, 0, 1, i != 0, 32'h500, 4'(i));
    add(1, 32'h5FF, 1, 1, 0, 0, 0, 0, 5);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 32'h600, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 1, 32'h600, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Mid-operation reset with count=4.
    for (int i = 0; i < 4; i++)
      add(1, 32'h700 + 32'(4 * i), 0, 0, 0, 1, i != 0, 32'h700, 4'(i));
    add(1, 32'h7F0, 1, 0, 1, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Empty-queue push with out_ready high.
`ifdef FETCH_QUEUE_BYPASS_EN
    add(1, 32'h200, 1, 0, 0, 1, 1, 32'h200, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
`else
    add(1, 32'h200, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 1, 32'h200, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
`endif

    // Hand sequence: reset held two cycles, handshakes closed throughout.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'hDEAD; in_inst = inst_of(32'hDEAD);
      #1;
      check1("reset_in_ready", -1, {31'b0, in_ready}, 32'd0);
      check1("reset_out_valid", -1, {31'b0, out_valid}, 32'd0);
      if (c == 1) check1("reset_count", -1, {28'b0, count}, 32'd0);
      $display("[TB] reset cycle %0d ir=%0b ov=%0b cnt=%0d", c, in_ready, out_valid, count);
    end

    foreach (vecs[i]) apply(vecs[i], i);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
